// File: rtl/io_pkg.sv
// io_pkg: shared widths, default port address and control-word bit for the I/O port.
package io_pkg;
   localparam int IO_DATA_W = 8;
   localparam int IO_ADDR_W = 8;
   localparam logic [IO_ADDR_W-1:0] IO_PORT_ADDR = 8'h01;
   localparam int CW_IO_OUT_EN = 11;
endpackage

// File: rtl/io_port_if.sv
// io_port_if: CPU bus strobes plus TX/RX stream handshakes of the I/O port.
interface io_port_if;
   import io_pkg::*;
   logic [IO_DATA_W-1:0] bus_in, out, tx_data, rx_data;
   logic addr_write_en, out_write_en, in_read_en, busy;
   logic tx_valid, tx_ready, rx_valid, rx_ready;
   modport slave (
      input bus_in, addr_write_en, out_write_en, in_read_en, tx_ready, rx_data, rx_valid,
      output out, busy, tx_data, tx_valid, rx_ready
   );
   modport master (
      output bus_in, addr_write_en, out_write_en, in_read_en, tx_ready, rx_data, rx_valid,
      input out, busy, tx_data, tx_valid, rx_ready
   );
endinterface

// File: rtl/io_fifo.sv
// io_fifo: power-of-two TX FIFO; pointers wrap naturally, push refused when full.
module io_fifo
   import io_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [IO_DATA_W-1:0] din,
   output logic [IO_DATA_W-1:0] dout,
   output logic                 full,
   output logic                 empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [IO_DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic do_push, do_pop;
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push & !full;
   assign do_pop  = pop & !empty;
   assign dout    = mem[rd_ptr];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/io_port.sv
// io_port: bus responder for OUT/IN; OUT bytes queue in a TX FIFO, IN bytes come
// from a one-entry RX holding register. busy stalls the controller step.
module io_port
   import io_pkg::*;
#(
   parameter logic [IO_ADDR_W-1:0] PORT_ADDR = IO_PORT_ADDR,
   parameter int                   DEPTH     = 4
) (
   input logic       clk,
   input logic       rst,
   io_port_if.slave  bus
);
   logic [IO_ADDR_W-1:0] addr;
   logic [IO_DATA_W-1:0] rx_buf;
   logic match, wr, rd, full, empty, rx_full, rx_cap;
   assign match = addr == PORT_ADDR;
   assign wr    = bus.out_write_en & match;
   // A simultaneous OUT and IN is illegal; OUT takes priority.
   assign rd    = bus.in_read_en & match & !bus.out_write_en;
   assign rx_cap = bus.rx_valid & !rx_full;
   assign bus.tx_valid = !empty;
   assign bus.rx_ready = rst & !rx_full;
   assign bus.busy     = rst & ((wr & full) | (rd & !rx_full));
   assign bus.out      = (rd & rx_full) ? rx_buf : '0;
   io_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr),
      .pop   (bus.tx_ready),
      .din   (bus.bus_in),
      .dout  (bus.tx_data),
      .full  (full),
      .empty (empty)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr    <= '0;
         rx_buf  <= '0;
         rx_full <= 1'b0;
      end else begin
         if (bus.addr_write_en) addr <= bus.bus_in;
         if (rx_cap) begin
            rx_buf  <= bus.rx_data;
            rx_full <= 1'b1;
         end else if (rd & rx_full) rx_full <= 1'b0;
      end
   end
endmodule

// File: tb/tb_io_port.sv
// tb_io_port: directed plan with literal expectations, then random traffic checked
// every cycle against a queue-based model of the port.
module tb_io_port;
   localparam logic [7:0] PA = 8'h01;
   logic clk = 0, rst = 0;
   int checks = 0, errors = 0;
   bit cmp_on = 0;
   io_port_if bus();
   io_port #(.PORT_ADDR(PA), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   logic [7:0] q[$];
   logic [7:0] m_addr, m_rxbuf;
   bit m_rxfull;

   task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         m_addr = 0; m_rxbuf = 0; m_rxfull = 0;
      end else begin
         bit m, push_ok, pop_ok, read, cap;
         m       = m_addr == PA;
         push_ok = bus.out_write_en && m && q.size() < 4;
         pop_ok  = q.size() > 0 && bus.tx_ready;
         read    = bus.in_read_en && m && !bus.out_write_en && m_rxfull;
         cap     = bus.rx_valid && !m_rxfull;
         if (pop_ok) void'(q.pop_front());
         if (push_ok) q.push_back(bus.bus_in);
         if (bus.addr_write_en) m_addr = bus.bus_in;
         if (cap) begin m_rxbuf = bus.rx_data; m_rxfull = 1; end
         else if (read) m_rxfull = 0;
      end
   end

   always @(negedge clk) begin
      #2;
      if (cmp_on) begin
         bit m, ir;
         m  = m_addr == PA;
         ir = m && bus.in_read_en && !bus.out_write_en;
         chk("tx_valid", {7'd0, bus.tx_valid}, {7'd0, q.size() != 0});
         if (q.size() != 0) chk("tx_data", bus.tx_data, q[0]);
         else if (!rst) chk("tx_data_rst", bus.tx_data, 8'h00);
         chk("busy", {7'd0, bus.busy},
             {7'd0, rst && ((m && bus.out_write_en && q.size() == 4) || (ir && !m_rxfull))});
         chk("out", bus.out, (ir && m_rxfull) ? m_rxbuf : 8'h00);
         chk("rx_ready", {7'd0, bus.rx_ready}, {7'd0, rst && !m_rxfull});
      end
   end

   task automatic nxt(); @(negedge clk); endtask
   task automatic clr();
      bus.addr_write_en = 0; bus.out_write_en = 0; bus.in_read_en = 0;
   endtask

   initial begin
      bus.bus_in = 0; bus.tx_ready = 0; bus.rx_data = 0; bus.rx_valid = 0;
      clr();
      cmp_on = 1;
      #3;
      chk("rst_tx_valid", {7'd0, bus.tx_valid}, 8'h00);
      chk("rst_tx_data", bus.tx_data, 8'h00);
      chk("rst_out", bus.out, 8'h00);
      chk("rst_busy", {7'd0, bus.busy}, 8'h00);
      chk("rst_rx_ready", {7'd0, bus.rx_ready}, 8'h00);
      nxt(); rst = 1;
      // OUT one byte, no bypass
      nxt(); bus.addr_write_en = 1; bus.bus_in = 8'h01;
      nxt(); clr(); bus.out_write_en = 1; bus.bus_in = 8'hA5; #3;
      chk("nobypass", {7'd0, bus.tx_valid}, 8'h00);
      nxt(); clr(); #3;
      chk("a5_valid", {7'd0, bus.tx_valid}, 8'h01);
      chk("a5_data", bus.tx_data, 8'hA5);
      nxt(); bus.tx_ready = 1;
      nxt(); bus.tx_ready = 0; #3;
      chk("a5_popped", {7'd0, bus.tx_valid}, 8'h00);
      // fill, then held fifth OUT
      for (int i = 0; i < 4; i++) begin
         nxt(); bus.out_write_en = 1; bus.bus_in = 8'h10 + 8'(i);
      end
      nxt(); bus.bus_in = 8'h14; #3;
      chk("full_busy", {7'd0, bus.busy}, 8'h01);
      chk("full_head", bus.tx_data, 8'h10);
      nxt(); bus.tx_ready = 1; #3;
      chk("full_pop_busy", {7'd0, bus.busy}, 8'h01);
      nxt(); bus.tx_ready = 0; #3;
      chk("retry_busy", {7'd0, bus.busy}, 8'h00);
      nxt(); clr(); bus.tx_ready = 1; #3;
      chk("drain0", bus.tx_data, 8'h11);
      nxt(); #3; chk("drain1", bus.tx_data, 8'h12);
      nxt(); #3; chk("drain2", bus.tx_data, 8'h13);
      nxt(); #3; chk("drain3", bus.tx_data, 8'h14);
      nxt(); bus.tx_ready = 0; #3;
      chk("drained", {7'd0, bus.tx_valid}, 8'h00);
      // RX capture then IN
      nxt(); bus.rx_valid = 1; bus.rx_data = 8'h3C; #3;
      chk("rx_ready_pre", {7'd0, bus.rx_ready}, 8'h01);
      nxt(); bus.rx_valid = 0; #3;
      chk("rx_ready_full", {7'd0, bus.rx_ready}, 8'h00);
      nxt(); bus.in_read_en = 1; #3;
      chk("in_3c", bus.out, 8'h3C);
      chk("in_busy0", {7'd0, bus.busy}, 8'h00);
      nxt(); clr(); #3;
      chk("rx_ready_back", {7'd0, bus.rx_ready}, 8'h01);
      chk("out_idle", bus.out, 8'h00);
      // IN stalls until a byte arrives
      nxt(); bus.in_read_en = 1; #3;
      chk("in_stall", {7'd0, bus.busy}, 8'h01);
      chk("in_stall_out", bus.out, 8'h00);
      nxt();
      nxt(); bus.rx_valid = 1; bus.rx_data = 8'h7E; #3;
      chk("in_stall2", {7'd0, bus.busy}, 8'h01);
      nxt(); bus.rx_valid = 0; #3;
      chk("in_7e_busy", {7'd0, bus.busy}, 8'h00);
      chk("in_7e", bus.out, 8'h7E);
      nxt(); clr();
      // non-matching address
      nxt(); bus.addr_write_en = 1; bus.bus_in = 8'h02; bus.rx_valid = 1; bus.rx_data = 8'h55;
      nxt(); clr(); bus.rx_valid = 0; bus.out_write_en = 1; bus.bus_in = 8'hFF; #3;
      chk("nm_out_busy", {7'd0, bus.busy}, 8'h00);
      nxt(); clr(); bus.in_read_en = 1; #3;
      chk("nm_in_busy", {7'd0, bus.busy}, 8'h00);
      chk("nm_in_out", bus.out, 8'h00);
      chk("nm_tx_valid", {7'd0, bus.tx_valid}, 8'h00);
      nxt(); clr(); #3;
      chk("nm_rx_held", {7'd0, bus.rx_ready}, 8'h00);
      // async reset mid-cycle
      nxt(); bus.addr_write_en = 1; bus.bus_in = 8'h01;
      nxt(); clr(); bus.out_write_en = 1; bus.bus_in = 8'h21;
      nxt(); bus.bus_in = 8'h22;
      nxt(); clr(); #3;
      chk("pre_rst_valid", {7'd0, bus.tx_valid}, 8'h01);
      #2 rst = 0; #1;
      chk("async_tx_valid", {7'd0, bus.tx_valid}, 8'h00);
      chk("async_rx_ready", {7'd0, bus.rx_ready}, 8'h00);
      nxt(); rst = 1; #3;
      chk("post_rst_valid", {7'd0, bus.tx_valid}, 8'h00);
      chk("post_rst_rx_ready", {7'd0, bus.rx_ready}, 8'h01);
      // random traffic
      for (int n = 0; n < 3000; n++) begin
         int op;
         nxt();
         clr();
         rst = ($urandom_range(0, 199) != 0);
         op = $urandom_range(0, 9);
         bus.bus_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ($urandom_range(0, 4) == 0 ? 8'h02 : PA);
         bus.addr_write_en = op == 0;
         bus.out_write_en  = op inside {[1:4]};
         bus.in_read_en    = op inside {[5:7]};
         bus.tx_ready = $urandom_range(0, 2) == 0;
         bus.rx_valid = $urandom_range(0, 2) != 0;
         bus.rx_data  = 8'($urandom);
      end
      nxt(); rst = 1; clr();
      nxt(); nxt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/io_port.md
Name: io_port

Overview:
- Bus-side responder for the CPU's OUT and IN instructions. It sits on the shared bus next to memory.
- The controller strobes it the same way it strobes the MAR and memory enables.
- OUT: bytes go into a small TX FIFO, which drains to an external consumer over a valid/ready handshake.
- IN: bytes come from an external producer into a one-entry RX holding register and are driven back toward the bus mux.
- busy lets the controller stall a step until the transfer can complete.

Parameters:
- PORT_ADDR, 8'h01, I/O address this instance answers to.
- DEPTH, 4, TX FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  CPU clock (gated clk_out domain).
- rst  input  1  asynchronous, active-low reset.
- bus_in  input  8  bus[7:0] from the top-level mux.
- addr_write_en  input  1  latch bus_in into the port-address register.
- out_write_en  input  1  OUT data strobe: push bus_in to the TX FIFO.
- in_read_en  input  1  IN data strobe: present RX data on out and consume it.
- out  output  8  read data to the bus mux; the top level gates it with its own io_out_en.
- busy  output  1  stall request to the controller.
- tx_data  output  8  FIFO head.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  external consumer accepts tx_data.
- rx_data  input  8  external producer data.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  RX register can accept.

Behaviour:
- Reset (rst low, asynchronous) clears all state:
  - address register = 8'h00, FIFO empty, rd/wr pointers 0, count 0.
  - rx_full = 0, rx_buf = 8'h00.
  - Outputs: tx_valid 0, tx_data 8'h00, out 8'h00, busy 0, rx_ready 0 while rst is low.
- Reset mid-transfer discards FIFO contents and the held RX byte. No partial handshake survives.
- Address decode:
  - addr_write_en: the address register takes bus_in at the rising clk edge.
  - match = (address register == PORT_ADDR), combinational.
- OUT path:
  - Push when out_write_en & match & !full, at the rising edge.
  - tx_valid = (count != 0); tx_data = mem[rd_ptr], registered storage.
  - Pop when tx_valid & tx_ready.
  - Pointers wrap modulo DEPTH. count width is clog2(DEPTH+1).
  - Latency: a byte pushed at edge N is visible on tx_valid/tx_data after edge N. There is no bypass, even with tx_ready high.
- IN path:
  - rx_ready = !rx_full.
  - Capture when rx_valid & rx_ready: rx_buf <= rx_data, rx_full <= 1.
  - When in_read_en & match & rx_full: out = rx_buf combinationally in the same cycle, and rx_full clears at the next edge.
  - Otherwise out = 8'h00.
- busy (combinational) = (out_write_en & match & full) | (in_read_en & match & !rx_full).
  - The controller holds its current micro-step while busy is high.
  - While busy, the strobe has no effect on state.
- Non-matching address: out_write_en and in_read_en are ignored, busy = 0, out = 8'h00.
- Simultaneous events:
  - Push and pop in one cycle while non-empty and not full: both happen, count unchanged.
  - FIFO full with push and pop in one cycle: the push is refused (full is evaluated before the edge), busy = 1, and the pop happens. The push is retried next cycle and succeeds.
  - FIFO empty with push (tx_ready high): only the push happens.
  - RX held byte read in the same cycle rx_valid is high: rx_ready is 0, so no capture. Capture occurs on a later cycle.
  - out_write_en and in_read_en together are illegal; the port services OUT only.

Decomposition:
- Shared package io_pkg:
  - IO_DATA_W = 8, IO_ADDR_W = 8, default PORT_ADDR.
  - The io_out_en control-word bit position, for the controller and top-level mux.
- Sub-module io_fifo (parameter DEPTH):
  - Ports: clk, rst, push, pop, din, dout, full, empty.
  - io_port instantiates it for the TX path.

Test Plan:
- Reset then addr_write_en with bus_in=8'h01, OUT 8'hA5 with tx_ready=0 -> tx_valid=1 and tx_data=8'hA5 one edge later; raising tx_ready pops it, tx_valid=0.
- Four OUTs 8'h10..8'h13 with tx_ready=0, then a fifth OUT 8'h14 -> busy=1 and FIFO unchanged. Raising tx_ready for one cycle pops 8'h10 and the held OUT is accepted. Drain order is 8'h11, 8'h12, 8'h13, 8'h14.
- rx_valid with rx_data=8'h3C -> rx_ready falls after the edge. IN -> out=8'h3C in the same cycle, busy=0, and rx_ready=1 after the edge.
- IN with rx_full=0 -> busy=1 and out=8'h00. rx_valid with 8'h7E two cycles later -> busy drops, out=8'h7E.
- Address register = 8'h02: OUT 8'hFF and IN -> no push, busy=0, out=8'h00, tx_valid stays 0.
- Push two bytes, pull rst low mid-cycle -> tx_valid=0 and rx_ready=0 immediately (asynchronously). After release, the FIFO is empty and rx_ready=1.
